// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared states, command byte and bit-cell timing for the N64 controller master
package n64_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_LOW,
    TX_HIGH,
    TX_STOP,
    RX_WAIT_FALL,
    RX_SAMPLE,
    RX_WAIT_HIGH,
    DONE
  } n64_state_e;

  localparam logic [7:0] N64_POLL_CMD     = 8'h01;
  localparam int         N64_QUARTER_CLKS = 4;
  localparam int         N64_CELL_Q       = 4;   // quarters per bit-cell
  localparam int         N64_ZERO_LOW_Q   = 3;   // low quarters for a '0'
  localparam int         N64_ONE_LOW_Q    = 1;   // low quarters for a '1' and the stop bit
  localparam int         N64_SAMPLE_Q     = 2;   // quarters from a device edge to the sample point
  localparam int         N64_RESP_BITS    = 34;
  localparam int         N64_TIMEOUT_CLKS = 256;

endpackage

// File: rtl/n64_line_sync.sv
// rtl/n64_line_sync.sv - 2-FF synchronizer for the pad line plus registered falling-edge detect
module n64_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic fall_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic fall_q, fall_d;

  // Next values: shift the raw line through the chain; an edge is high-then-low on the synchronized stage
  always_comb begin
    s1_d   = line_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    fall_d = s3_q & ~s2_q;
  end

  // Chain resets to the idle (pulled-up) level so reset never produces a false edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      fall_q <= fall_d;
    end
  end

  assign line_sync  = s2_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/n64_controller.sv
// rtl/n64_controller.sv - N64 pad bus master: poll command TX, 34-bit response RX; N64_RX_TIMEOUT_EN adds an RX wait timeout
module n64_controller
  import n64_pkg::*;
#(
`ifdef N64_RX_TIMEOUT_EN
  parameter int         TIMEOUT_CLKS = N64_TIMEOUT_CLKS,
`endif
  parameter int         QUARTER_CLKS = N64_QUARTER_CLKS,
  parameter logic [7:0] POLL_CMD     = N64_POLL_CMD,
  parameter int         RESP_BITS    = N64_RESP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [RESP_BITS-1:0] data,
  output logic                 readValid,
  inout  wire                  dataController
);

  localparam int TW = 16;
  localparam int CW = $clog2(RESP_BITS + 1);

  localparam logic [TW-1:0] ZERO_LOW_CLKS = TW'(N64_ZERO_LOW_Q * QUARTER_CLKS);
  localparam logic [TW-1:0] ONE_LOW_CLKS  = TW'(N64_ONE_LOW_Q * QUARTER_CLKS);
  localparam logic [TW-1:0] CELL_CLKS     = TW'(N64_CELL_Q * QUARTER_CLKS);
  localparam logic [TW-1:0] STOP_CLKS     = TW'(N64_ONE_LOW_Q * QUARTER_CLKS);
  localparam logic [TW-1:0] SAMPLE_CLKS   = TW'(N64_SAMPLE_Q * QUARTER_CLKS);
  localparam logic [CW-1:0] LAST_BIT      = CW'(RESP_BITS - 1);
`ifdef N64_RX_TIMEOUT_EN
  localparam logic [TW-1:0] TIMEOUT_LIM   = TW'(TIMEOUT_CLKS);
`endif

  n64_state_e           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [CW-1:0]        count_q, count_d;
  logic [RESP_BITS-1:0] shift_q, shift_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic                 read_valid_q, read_valid_d;
  logic                 drive_low_q, drive_low_d;
  logic [TW-1:0]        low_clks;
  logic                 line_sync;
  logic                 fall_pulse;

  n64_line_sync u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .line_in    (dataController),
    .line_sync  (line_sync),
    .fall_pulse (fall_pulse)
  );

  // Next-state, bit-cell timing and response capture; timer restarts on every state change
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_idx_d = bit_idx_q;
    count_d   = count_q;
    shift_d   = shift_q;
    data_d    = data_q;
    low_clks  = POLL_CMD[bit_idx_q] ? ONE_LOW_CLKS : ZERO_LOW_CLKS;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (start) begin
          state_d   = TX_LOW;
          bit_idx_d = 3'd7;
        end
      end
      TX_LOW: begin
        if (timer_q == low_clks - TW'(1)) begin
          state_d = TX_HIGH;
          timer_d = '0;
        end
      end
      TX_HIGH: begin
        if (timer_q == CELL_CLKS - low_clks - TW'(1)) begin
          timer_d = '0;
          if (bit_idx_q == 3'd0) begin
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q - 3'd1;
            state_d   = TX_LOW;
          end
        end
      end
      TX_STOP: begin
        if (timer_q == STOP_CLKS - TW'(1)) begin
          state_d = RX_WAIT_FALL;
          timer_d = '0;
          count_d = '0;
          shift_d = '0;
        end
      end
      RX_WAIT_FALL: begin
        if (fall_pulse) begin
          state_d = RX_SAMPLE;
          timer_d = '0;
        end
`ifdef N64_RX_TIMEOUT_EN
        else if (timer_q == TIMEOUT_LIM - TW'(1)) begin
          state_d = IDLE;
          timer_d = '0;
        end
`endif
      end
      RX_SAMPLE: begin
        if (timer_q == SAMPLE_CLKS - TW'(1)) begin
          shift_d = {shift_q[RESP_BITS-2:0], line_sync};
          timer_d = '0;
          if (count_q == LAST_BIT) begin
            state_d = DONE;
            data_d  = shift_d;
          end else begin
            count_d = count_q + 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (line_sync) begin
          state_d = RX_WAIT_FALL;
          timer_d = '0;
        end
`ifdef N64_RX_TIMEOUT_EN
        else if (timer_q == TIMEOUT_LIM - TW'(1)) begin
          state_d = IDLE;
          timer_d = '0;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    read_valid_d = (state_d == DONE);
    drive_low_d  = (state_d == TX_LOW) || (state_d == TX_STOP);
  end

  // State and datapath registers; pad drive and strobe are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      count_q      <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      read_valid_q <= 1'b0;
      drive_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      read_valid_q <= read_valid_d;
      drive_low_q  <= drive_low_d;
    end
  end

  assign dataController = drive_low_q ? 1'b0 : 1'bz;
  assign data           = data_q;
  assign readValid      = read_valid_q;

endmodule

// File: tb/tb_n64_controller.sv
// tb/tb_n64_controller.sv - scoreboard bench for n64_controller with bus monitor and mock pad device
module tb_n64_controller;

  localparam logic [7:0] CMD = 8'h01;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dev_low;
  logic [33:0] data;
  logic        readValid;
  wire         bus;

  pullup (bus);
  assign bus = dev_low ? 1'b0 : 1'bz;

  n64_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .data           (data),
    .readValid      (readValid),
    .dataController (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          rv_count     = 0;
  int          rv_expected  = 0;
  logic        rv_prev      = 1'b0;
  logic [33:0] sb_q[$];
  logic [33:0] exp_word;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // readValid monitor: one-cycle strobe, data compared against the scoreboard
  always @(negedge clk) begin
    if (readValid === 1'b1) begin
      rv_count++;
      check_eq("rv_pulse_width", {63'd0, rv_prev}, 64'd0);
      check_eq("sb_has_entry", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() != 0) begin
        exp_word = sb_q.pop_front();
        check_eq("rx_data", {30'd0, data}, {30'd0, exp_word});
      end
    end
    rv_prev = readValid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_tx();
    int low;
    int high;
    int waited;
    int exp_low;
    waited = 0;
    @(negedge clk);
    while (bus !== 1'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("tx_start_seen", {63'd0, bus === 1'b0}, 64'd1);
    if (bus !== 1'b0) return;
    for (int i = 0; i < 9; i++) begin
      low = 0;
      while (bus === 1'b0 && low < 40) begin
        low++;
        @(negedge clk);
      end
      high = 0;
      while (bus !== 1'b0 && high < ((i < 8) ? 40 : 16)) begin
        high++;
        @(negedge clk);
      end
      if (i < 8) begin
        exp_low = CMD[7-i] ? 4 : 12;
        check_eq($sformatf("tx_bit%0d", 7 - i), {low[31:0], high[31:0]},
                 {exp_low[31:0], 32'(16 - exp_low)});
      end else begin
        check_eq("tx_stop", {low[31:0], high[31:0]}, {32'd4, 32'd16});
      end
    end
  endtask

  task automatic dev_reply(input logic [33:0] resp, input int start_at, input int abort_at);
    int  lowc;
    bit  aborted;
    aborted = 1'b0;
    if (abort_at < 0) begin
      sb_q.push_back(resp);
      rv_expected++;
    end
    repeat (20) @(posedge clk);
    #1;
    for (int b = 0; b < 34 && !aborted; b++) begin
      lowc = resp[33-b] ? 4 : 12;
      for (int c = 0; c < 16 && !aborted; c++) begin
        if (b == abort_at && c == 6) begin
          dev_low = 1'b0;
          reset   = 1'b1;
          @(posedge clk); #1 reset = 1'b0;
          aborted = 1'b1;
        end else begin
          dev_low = (c < lowc);
          start   = (b == start_at) && (c == 0);
          @(posedge clk); #1;
        end
      end
    end
    dev_low = 1'b0;
    start   = 1'b0;
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus === 1'b0) lows++;
    end
    check_eq(tag, lows, 0);
  endtask

  task automatic poll(input logic [33:0] resp, input int start_at, input int abort_at);
    pulse_start();
    check_tx();
    dev_reply(resp, start_at, abort_at);
    if (abort_at >= 0) begin
      check_eq("rst_bus_released", {63'd0, bus === 1'b1}, 64'd1);
      check_eq("rst_data", {30'd0, data}, 64'd0);
      check_eq("rst_read_valid", {63'd0, readValid}, 64'd0);
      repeat (40) @(posedge clk);
      check_eq("rst_no_strobe", rv_count, rv_expected);
    end else begin
      quiet_check("no_extra_tx", 40);
      check_eq("rv_count", rv_count, rv_expected);
    end
  endtask

  initial begin
    dev_low = 1'b0;
    start   = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_data", {30'd0, data}, 64'd0);
    check_eq("reset_read_valid", {63'd0, readValid}, 64'd0);
    check_eq("reset_bus", {63'd0, bus === 1'b1}, 64'd1);

    poll(34'h2_AAAA_5555, -1, -1);
    poll(34'h0_0000_0000, -1, -1);
    poll(34'h3_FFFF_FFFF, -1, -1);
    poll(34'h1_2345_6789, 10, -1);
    poll(34'h1_5A5A_A5A5, -1, 15);
    poll(34'h0_F0F0_0F0F, -1, -1);

    pulse_start();
    check_tx();
    repeat (300) @(posedge clk);
    #1;
    check_eq("no_device_no_strobe", rv_count, rv_expected);
`ifdef N64_RX_TIMEOUT_EN
    pulse_start();
    check_tx();
    repeat (300) @(posedge clk);
    #1;
    check_eq("timeout_no_strobe", rv_count, rv_expected);
`else
    pulse_start();
    quiet_check("stuck_in_rx", 60);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    poll(34'h2_0F0F_F0F0, -1, -1);
`endif

    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("rv_total", rv_count, rv_expected);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/n64_controller.md
Name: n64_controller

Overview:
Host-side master for the single-wire, open-drain N64 controller bus. A `start` pulse makes the block transmit the 8-bit poll command and a stop bit. It then releases the line, receives a 34-bit response from the device, and presents the response on `data` with a one-cycle `readValid` strobe. It sits between the game logic (button consumer) and the external pad pin.

Parameters:
QUARTER_CLKS, 4, clk cycles per quarter bit-cell; one bit-cell = 4 quarters = 16 clks.
POLL_CMD, 8'h01, command byte sent, MSB first.
RESP_BITS, 34, number of response bits captured.
TIMEOUT_CLKS, 256, max clks waiting for a device falling edge (only with N64_RX_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a poll transaction; sampled high in IDLE
data  output  RESP_BITS  last completed response, MSB = first bit received
readValid  output  1  one-cycle strobe, data valid
dataController  inout  1  open-drain bus: drives 1'b0 or 'z; external pull-up supplies high

Behaviour:
- Reset (synchronous, active-high), any state: state=IDLE, line released ('z), data=0, readValid=0, all counters 0. Applies mid-TX or mid-RX; partial response discarded.
- Bit-cell encoding:
  - '0' = 3 quarters low, 1 quarter released.
  - '1' = 1 quarter low, 3 quarters released.
  - Host stop bit = 1 quarter low, then released; host goes straight to RX after that quarter.
- States and transitions:
  - IDLE: line released. start=1 -> TX_LOW with bit index 7.
  - TX_LOW: drive 0 for 1 quarter (bit=1) or 3 quarters (bit=0) -> TX_HIGH.
  - TX_HIGH: release for the remainder of the 4-quarter cell. Index>0: decrement, -> TX_LOW. Index 0 -> TX_STOP.
  - TX_STOP: drive 0 for 1 quarter, release -> RX_WAIT_FALL with count 0.
  - RX_WAIT_FALL: wait for a falling edge on the synchronized line -> RX_SAMPLE, timer cleared.
  - RX_SAMPLE: after 2 quarters (8 clks) from the edge, sample the line (high=1, low=0) and shift into a shift register, MSB first.
    - count = RESP_BITS-1 -> DONE.
    - otherwise -> RX_WAIT_HIGH.
  - RX_WAIT_HIGH: wait for the synchronized line to be high -> RX_WAIT_FALL.
  - DONE: one cycle; data <= shift register, readValid=1 -> IDLE.
- Input sampling: bus read through a 2-FF synchronizer; the falling edge is detected on the synchronized value. The block never samples its own drive during TX.
- Latency: readValid asserts exactly 1 clk after the last-bit sample. data changes only in DONE and holds until the next DONE or reset.
- start while not IDLE: ignored. start held high: a new transaction begins the cycle after DONE returns to IDLE.
- readValid is never high for more than one cycle, and is low in all states except DONE.

Optional Feature:
Macro N64_RX_TIMEOUT_EN.
- Defined: in RX_WAIT_FALL and RX_WAIT_HIGH, a counter reloads on each state entry. If it reaches TIMEOUT_CLKS, the block goes to IDLE with readValid=0 and data unchanged.
- Undefined: no counter; the block waits indefinitely for the device (only reset recovers it).

Decomposition:
- Package n64_pkg holds:
  - state enum (IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT_FALL, RX_SAMPLE, RX_WAIT_HIGH, DONE)
  - N64_POLL_CMD
  - quarter counts for 0/1 low times
  - RESP_BITS default
- One sub-module, n64_line_sync: 2-FF synchronizer plus registered falling-edge detect. Outputs line_sync and fall_pulse.

Test Plan:
- Reset, then start pulse 1 clk; bus monitor:
  - bits 7..1 each 12 clks low / 4 released;
  - bit 0 4 low / 12 released;
  - stop 4 low, then released.
- Mock device answers 34'h2_AAAA_5555 after the stop bit -> one readValid pulse, data==34'h2_AAAA_5555, then IDLE.
- Responses 34'h0 and 34'h3_FFFF_FFFF -> data matches exactly; readValid high exactly 1 clk each.
- Second start pulse during RX -> ignored; the first response completes unchanged; no extra TX on the bus.
- reset asserted mid-RX (bit 15) -> next clk line released, data==0, readValid stays 0. A following start completes normally.
- N64_RX_TIMEOUT_EN defined, no device (pull-up only) -> return to IDLE 256 clks after the stop bit; readValid never asserts. Undefined -> remains in RX_WAIT_FALL.
